// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
//
// Purpose:
//   Operand forwarding select and load-use hazard detection for an in-order
//   pipeline. Each ID/EX source operand gets a registered forward select that
//   points at the newest in-flight producer. Decode operands that depend on a
//   load still sitting in ID/EX cause a stall (PC/IF-ID hold plus an ID/EX
//   bubble) lasting LOAD_LAT cycles. With forwarding disabled, any in-flight
//   producer match also stalls, combinationally, for as long as it persists.
//
// Parameters:
//   NSRC     - source operands per instruction (1..4)
//   AW       - register address width
//   LOAD_LAT - load-use stall cycles (1..8)
//
// Ports:
//   clk         - clock, all state on rising edge
//   reset       - synchronous active-high reset
//   ie_src      - ID/EX source addresses, operand i at [i*AW +: AW]
//   id_src      - decode source addresses, same packing
//   id_used     - decode operand i is actually read
//   ie_rd/em_rd/mw_rd       - destination register of ID/EX, EX/MEM, MEM/WB
//   ie_regw/em_regw/mw_regw - register write enable of the same stages
//   ie_memread  - ID/EX instruction is a load
//   fwd_en      - 1 = forwarding mode, 0 = stall-only mode
//   fwd_sel     - per operand [2i +: 2]: 0 regfile, 1 MEM/WB, 2 EX/MEM
//   stall       - hold PC and IF/ID
//   flush_ie    - insert bubble into ID/EX
//   stall_cnt   - remaining multi-cycle stall count (debug)

module forward_hazard_unit #(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   ie_src,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_used,
    input  logic [AW-1:0]        ie_rd,
    input  logic [AW-1:0]        em_rd,
    input  logic [AW-1:0]        mw_rd,
    input  logic                 ie_regw,
    input  logic                 em_regw,
    input  logic                 mw_regw,
    input  logic                 ie_memread,
    input  logic                 fwd_en,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall,
    output logic                 flush_ie,
    output logic [2:0]           stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The first stall cycle is spent in IDLE, so HOLD covers the rest.
    localparam logic [2:0] CNT_LOAD  = 3'(LOAD_LAT - 1);
    localparam bit         MULTI_CYC = (LOAD_LAT > 1);

    state_t               r_state;
    state_t               w_stateNext;
    logic [2:0]           r_stallCnt;
    logic [2:0]           w_stallCntNext;
    logic [2*NSRC-1:0]    r_fwdSel;
    logic [2*NSRC-1:0]    w_fwdSelNext;
    logic [NSRC-1:0]      w_loadHit;
    logic [NSRC-1:0]      w_noFwdHit;
    logic                 w_anyHit;
    logic                 w_anyLoadHit;
    logic                 w_stall;

    // Forward select per ID/EX operand. EX/MEM holds the newer value, so it
    // is tested first. Register 0 is hardwired and never forwarded.
    always_comb begin
        w_fwdSelNext = '0;
        if (fwd_en) begin
            for (int i = 0; i < NSRC; i++) begin
                if (em_regw && (em_rd != '0) && (em_rd == ie_src[i*AW +: AW])) begin
                    w_fwdSelNext[2*i +: 2] = 2'd2;
                end else if (mw_regw && (mw_rd != '0) && (mw_rd == ie_src[i*AW +: AW])) begin
                    w_fwdSelNext[2*i +: 2] = 2'd1;
                end
            end
        end
    end

    // Decode-side hazards. Load hits can start a multi-cycle hold; stall-only
    // hits just stall while the producer is still in flight. A nonzero source
    // that equals rd implies rd is nonzero as well.
    always_comb begin
        w_loadHit  = '0;
        w_noFwdHit = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_used[i] && (id_src[i*AW +: AW] != '0)) begin
                w_loadHit[i] = ie_regw && ie_memread && (id_src[i*AW +: AW] == ie_rd);
                w_noFwdHit[i] = !fwd_en &&
                                ((ie_regw && (id_src[i*AW +: AW] == ie_rd)) ||
                                 (em_regw && (id_src[i*AW +: AW] == em_rd)) ||
                                 (mw_regw && (id_src[i*AW +: AW] == mw_rd)));
            end
        end
        w_anyLoadHit = |w_loadHit;
        w_anyHit     = |(w_loadHit | w_noFwdHit);
    end

    // Stall FSM next state and outputs. HOLD ignores inputs entirely so the
    // counter cannot be reloaded mid-stall; reset masks the stall outputs.
    always_comb begin
        w_stateNext    = r_state;
        w_stallCntNext = r_stallCnt;
        w_stall        = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_anyHit;
                if (w_anyLoadHit && MULTI_CYC) begin
                    w_stateNext    = HOLD;
                    w_stallCntNext = CNT_LOAD;
                end
            end
            HOLD: begin
                w_stall = 1'b1;
                if (r_stallCnt <= 3'd1) begin
                    w_stateNext    = IDLE;
                    w_stallCntNext = 3'd0;
                end else begin
                    w_stallCntNext = r_stallCnt - 3'd1;
                end
            end
            default: begin
                w_stateNext    = IDLE;
                w_stallCntNext = 3'd0;
            end
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    // State, counter and forward-select registers. Reset drops any hold in
    // progress immediately so no residual stall cycle follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_stallCnt <= 3'd0;
            r_fwdSel   <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_stallCnt <= w_stallCntNext;
            r_fwdSel   <= w_fwdSelNext;
        end
    end

    assign fwd_sel   = r_fwdSel;
    assign stall     = w_stall;
    assign flush_ie  = w_stall;
    assign stall_cnt = r_stallCnt;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter NSRC, default 2: number of source operands per instruction, range 1..4.
REQ-002 Parameter AW, default 5: register-address width.
REQ-003 Parameter LOAD_LAT, default 1: load-use stall cycles, range 1..8.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 ie_src  in  NSRC*AW  ID/EX source register addresses; operand i is at bits [i*AW +: AW].
REQ-007 id_src  in  NSRC*AW  IF/ID (decode) source register addresses; same packing as ie_src.
REQ-008 id_used  in  NSRC  bit i set when decode operand i is actually read.
REQ-009 ie_rd, em_rd, mw_rd  in  AW each  destination register of the ID/EX, EX/MEM and MEM/WB stages.
REQ-010 ie_regw, em_regw, mw_regw  in  1 each  register-write enable of the matching stage.
REQ-011 ie_memread  in  1  instruction in ID/EX is a load.
REQ-012 fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode.
REQ-013 fwd_sel  out  2*NSRC  registered forward select per operand i at bits [2i +: 2]: 0 = register file, 1 = MEM/WB, 2 = EX/MEM; 3 is never driven.
REQ-014 stall  out  1  hold the PC and IF/ID.
REQ-015 flush_ie  out  1  insert a bubble into ID/EX.
REQ-016 stall_cnt  out  3  remaining stall cycles, for debug.

Function
REQ-017 fwd_sel SHALL be registered and computed per operand independently: on each posedge, operand i is evaluated from that cycle's ie_src, em_*, mw_* inputs, giving 1-cycle latency.
REQ-018 Per operand, fwd_sel SHALL be 2 if em_regw, em_rd!=0 and em_rd==src; else 1 if mw_regw, mw_rd!=0 and mw_rd==src; else 0 (EX/MEM has priority).
REQ-019 When fwd_en=0, all fwd_sel fields SHALL be loaded with 0.
REQ-020 Decode hazard hit(i) = id_used[i] and id_src_i!=0 and id_src_i==ie_rd and ie_regw and ie_memread.
REQ-021 When fwd_en=0, hit(i) SHALL additionally be true on any regw match, with rd!=0, against ie_rd, em_rd or mw_rd, regardless of ie_memread.
REQ-022 The FSM SHALL have two states, IDLE and HOLD.
REQ-023 In IDLE, stall = flush_ie = OR of hit(i), combinationally in the same cycle.
REQ-024 In HOLD, stall = flush_ie = 1 regardless of inputs.
REQ-025 IDLE->HOLD SHALL occur on a posedge where a load-caused hit is true and LOAD_LAT>1; stall_cnt SHALL load LOAD_LAT-1.
REQ-026 In HOLD, stall_cnt SHALL decrement each cycle; when stall_cnt==1 the next state SHALL be IDLE and stall_cnt SHALL become 0.
REQ-027 When LOAD_LAT=1, the FSM SHALL never enter HOLD and each load hit SHALL stall exactly one cycle.
REQ-028 Hits SHALL NOT be re-evaluated and stall_cnt SHALL NOT be reloaded while in HOLD.
REQ-029 Hits caused only by REQ-021 SHALL NOT start HOLD; they stall combinationally while they persist.
REQ-030 fwd_sel SHALL keep updating per REQ-017 during stalls.

Reset
REQ-031 reset=1 at a posedge SHALL set fwd_sel=0, stall_cnt=0 and state=IDLE.
REQ-032 While reset=1, stall and flush_ie SHALL be forced to 0.
REQ-033 Reset asserted while in HOLD SHALL abort the stall and return to IDLE on that edge, with no residual stall cycle.

Verification
REQ-034 Test: em_regw=1, em_rd=3, mw_regw=1, mw_rd=3, ie_src0=3 -> fwd_sel[1:0]=2 one cycle later, not 1.
REQ-035 Test: em_rd=4 matches ie_src0 and mw_rd=5 matches ie_src1, both regw=1 -> fwd_sel=4'b0110 (operands forwarded independently).
REQ-036 Test: rd=0 with regw=1 matching a src=0 -> fwd_sel=0 and stall=0.
REQ-037 Test: LOAD_LAT=3, ie_memread=1, ie_rd=7, id_src1=7, id_used=2'b10 -> stall high for exactly 3 cycles, stall_cnt sequence 2,1,0.
REQ-038 Test: fwd_en=0, em_regw=1, em_rd=9, id_src0=9 used -> stall and flush_ie high while the match persists, fwd_sel=0.
REQ-039 Test: reset pulsed during the second HOLD cycle -> stall=0 on the following cycle, stall_cnt=0, state IDLE.
